// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with valid/ready handshake,
// optional two-entry skid buffer, NOP insertion and flush.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int unsigned      SKID      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // State encoding equals the number of held entries.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       st_q;
  logic [1:0]       st_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             main_valid;
  logic             skid_valid;
  logic             in_fire;
  logic             out_fire;

  assign main_valid = (st_q != EMPTY);
  assign skid_valid = (st_q == TWO);

  assign in_ready = (SKID != 0) ? ~skid_valid
                  : (out_ready | ~main_valid);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_q : NOP_VALUE;
  assign occupancy = st_q;

  always_comb begin
    st_d   = st_q;
    main_d = main_q;
    skid_d = skid_q;
    if (SKID != 0) begin
      unique case (st_q)
        EMPTY: begin
          if (in_fire) begin
            st_d   = ONE;
            main_d = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            st_d   = TWO;
            skid_d = in_data;
          end else if (out_fire) begin
            st_d   = EMPTY;
            main_d = NOP_VALUE;
          end
        end
        TWO: begin
          if (out_fire) begin
            st_d   = ONE;
            main_d = skid_q;
          end
        end
        default: begin
          st_d   = EMPTY;
          main_d = NOP_VALUE;
        end
      endcase
    end else begin
      if (in_fire) begin
        st_d   = ONE;
        main_d = in_data;
      end else if (out_fire) begin
        st_d   = EMPTY;
        main_d = NOP_VALUE;
      end
    end
    // Flush discards held entries and any same-cycle input.
    if (flush) begin
      st_d   = EMPTY;
      main_d = NOP_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q   <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= '0;
    end else begin
      st_q   <= st_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random checks of pipe_stage_skid against
// a FIFO scoreboard, for SKID=1 and SKID=0 instances.
module tb_pipe_stage_skid;

  localparam logic [63:0] B_NOP = 64'hFFFF_FFFF_0000_0000;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_flush;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [31:0] a_in_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [31:0] a_out_data;
  logic [1:0]  a_occ;

  logic        b_flush;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [63:0] b_in_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [63:0] b_out_data;
  logic [1:0]  b_occ;

  logic [31:0] qa[$];
  logic [63:0] qb[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .WIDTH(32), .NOP_VALUE(32'h0), .SKID(1)
  ) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_skid #(
    .WIDTH(64), .NOP_VALUE(B_NOP), .SKID(0)
  ) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Check both DUTs against the scoreboards, then advance one clock.
  task automatic step();
    logic        fi;
    logic        fo;
    logic [31:0] ea;
    logic [63:0] eb;
    #1;
    fi = a_in_valid && a_in_ready;
    fo = a_out_valid && a_out_ready;
    chk("a_occ", 64'(a_occ), 64'(qa.size()));
    chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
    chk("a_in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
    if (!a_out_valid) chk("a_nop", 64'(a_out_data), 64'h0);
    if (fo && qa.size() != 0) begin
      ea = qa.pop_front();
      chk("a_data", 64'(a_out_data), 64'(ea));
    end
    if (!rst || a_flush) qa.delete();
    else if (fi) qa.push_back(a_in_data);

    fi = b_in_valid && b_in_ready;
    fo = b_out_valid && b_out_ready;
    chk("b_occ", 64'(b_occ), 64'(qb.size()));
    chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
    chk("b_in_ready", 64'(b_in_ready),
        64'(b_out_ready || qb.size() == 0));
    if (!b_out_valid) chk("b_nop", b_out_data, B_NOP);
    if (fo && qb.size() != 0) begin
      eb = qb.pop_front();
      chk("b_data", b_out_data, eb);
    end
    if (!rst || b_flush) qb.delete();
    else if (fi) qb.push_back(b_in_data);

    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    a_flush     = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'hDEAD;
    a_out_ready = 1'b1;
    b_flush     = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 64'hDEAD;
    b_out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset held with traffic offered.
    step();
    step();

    // Streaming 1..8 with out_ready high.
    rst        = 1'b1;
    b_in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'(i);
      step();
    end
    a_in_valid = 1'b0;
    step();
    step();

    // Backpressure: A, B, C with a stalled consumer.
    a_in_valid  = 1'b1;
    a_in_data   = 32'hA;
    a_out_ready = 1'b1;
    step();
    a_in_data   = 32'hB;
    a_out_ready = 1'b0;
    step();
    a_in_data = 32'hC;
    step();
    chk("a_bp_in_ready", 64'(a_in_ready), 64'h0);
    step();
    a_out_ready = 1'b1;
    step();
    step();
    a_in_valid = 1'b0;
    step();
    step();

    // Flush in TWO with an input offered.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h10;
    step();
    a_in_data = 32'h11;
    step();
    a_flush   = 1'b1;
    a_in_data = 32'h12;
    step();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    chk("a_flush_occ", 64'(a_occ), 64'h0);
    chk("a_flush_rdy", 64'(a_in_ready), 64'h1);
    a_out_ready = 1'b1;
    step();
    step();

    // Flush in ONE with an accepted input that must be dropped.
    a_in_valid  = 1'b1;
    a_in_data   = 32'h13;
    a_out_ready = 1'b0;
    step();
    a_in_data = 32'h14;
    a_flush   = 1'b1;
    a_out_ready = 1'b1;
    step();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    step();
    step();

    // Flush and reset together.
    a_in_valid  = 1'b1;
    a_in_data   = 32'h30;
    a_out_ready = 1'b0;
    step();
    rst     = 1'b0;
    a_flush = 1'b1;
    step();
    rst        = 1'b1;
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    step();

    // Random traffic on both instances with a reset pulse.
    for (int i = 0; i < 200; i++) begin
      rst         = (i == 120) ? 1'b0 : 1'b1;
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in_data   = $urandom;
      a_out_ready = 1'($urandom_range(0, 1));
      a_flush     = ($urandom_range(0, 24) == 0);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_in_data   = {$urandom, $urandom};
      b_out_ready = 1'($urandom_range(0, 1));
      b_flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    rst         = 1'b1;
    a_flush     = 1'b0;
    b_flush     = 1'b0;
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    step();
    step();
    step();
    chk("a_drained", 64'(a_occ), 64'h0);
    chk("b_drained", 64'(b_occ), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
